change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Payout end of the coin path: vending_machine_top accepts coins through the debounced
//  btn_coin1/2/5 inputs, and this block returns change. It takes a change amount from
//  the controller (change_due) over a valid/ready handshake. It ejects $5/$2/$1 coins
//  greedily, as timed pulses to the coin-return solenoids, and tracks coin-tube stock.
//  It reports any amount it could not pay back to the controller.
// PARAMETERS
//  PULSE_CYCLES  4   solenoid pulse width in clk cycles (>=1)
//  GAP_CYCLES    4   low time between consecutive ejects in clk cycles (>=1)
//  COIN_CAP      15  tube capacity per denomination (<=15; counts are 4 bits)
//  INIT_COINS    10  per-tube count loaded on reset (<=COIN_CAP)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid     in   1  change request valid
//  req_amount    in   8  change to pay, in dollars
//  req_ready     out  1  high only in IDLE; transfer when req_valid&&req_ready
//  refill        in   1  sets all tubes to COIN_CAP; honoured in IDLE only
//  eject5        out  1  $5 solenoid pulse
//  eject2        out  1  $2 solenoid pulse
//  eject1        out  1  $1 solenoid pulse
//  tube5         out  4  $5 coins in stock
//  tube2         out  4  $2 coins in stock
//  tube1         out  4  $1 coins in stock
//  busy          out  1  high in every state except IDLE
//  done          out  1  one-cycle pulse when a request completes
//  short_flag    out  1  valid with done: amount not fully paid
//  short_amount  out  8  valid with done: unpaid remainder (0 if fully paid)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - State IDLE; eject*/done/short_flag=0; short_amount=0; remaining=0.
//   - tube*=INIT_COINS; req_ready=1 once rst=1.
//   - Reset mid-pulse drops eject* immediately. No partial state survives.
//  FSM states: IDLE, SELECT, PULSE, GAP, DONE.
//   - IDLE:
//     - On handshake, latch remaining=req_amount and go to SELECT.
//     - Else, if refill=1, set all tubes to COIN_CAP.
//     - Handshake and refill in the same cycle: the handshake wins; refill is dropped.
//   - SELECT (1 cycle): pick the largest d in {5,2,1} with d<=remaining and tube_d>0.
//     - If one exists: tube_d-=1 and remaining-=d on this edge, then go to PULSE.
//     - Else go to DONE. This covers remaining==0 and the stock-out case.
//   - PULSE: eject_d=1 for exactly PULSE_CYCLES cycles, then GAP.
//     - Exactly one eject* is high at any time.
//   - GAP: all eject*=0 for GAP_CYCLES cycles, then SELECT.
//   - DONE (1 cycle): done=1; short_amount=remaining; short_flag=(remaining!=0).
//     - Next state IDLE. short_* hold until the next DONE or reset.
//  Latency:
//   - The first eject rises 2 cycles after the handshake edge.
//   - Each coin takes 1+PULSE_CYCLES+GAP_CYCLES cycles.
//   - amount=0: done 2 cycles after handshake, no ejects.
//  Boundaries:
//   - Greedy selection skips an empty tube and uses smaller coins. Example: $5 empty,
//     amount 5 gives 2,2,1.
//   - A tube never underflows.
//   - req_valid while busy is ignored (ready=0); the requester holds it.
//   - req_amount is sampled only at the handshake. Later changes have no effect.
//   - refill while busy is ignored.
// TESTING
//  1. Reset, request 2:
//     - One eject2 pulse 4 cycles wide, starting 2 cycles after the handshake.
//     - done then follows with short_flag=0; tube2=9.
//  2. Request 8:
//     - Pulses in order eject5, eject2, eject1, each 4 high with a 4-cycle gap.
//     - tubes 9/9/9; done with short_amount=0.
//  3. Request 0: no ejects; done 2 cycles after the handshake; short_flag=0.
//  4. Drain tube5 to 0, then request 5:
//     - Pulses eject2, eject2, eject1; tube2 down 2, tube1 down 1; short_flag=0.
//  5. All tubes empty, request 3:
//     - No ejects; done with short_flag=1 and short_amount=3.
//     - Then refill in IDLE gives tubes=15.
//  6. rst=0 mid-eject5 pulse:
//     - eject5 drops the same cycle; tubes return to 10; req_ready=1 after release.
//  7. req_valid held high while busy: no second acceptance until IDLE.
//     - refill pulsed while busy: tubes unchanged.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser bundle: change request handshake, tube refill,
// solenoid pulses, tube stock and completion report.
interface change_dispenser_if;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       refill;
    logic       eject5;
    logic       eject2;
    logic       eject1;
    logic [3:0] tube5;
    logic [3:0] tube2;
    logic [3:0] tube1;
    logic       busy;
    logic       done;
    logic       short_flag;
    logic [7:0] short_amount;

    modport master (
        output req_valid, req_amount, refill,
        input  req_ready, eject5, eject2, eject1, tube5, tube2, tube1,
        input  busy, done, short_flag, short_amount
    );

    modport slave (
        input  req_valid, req_amount, refill,
        output req_ready, eject5, eject2, eject1, tube5, tube2, tube1,
        output busy, done, short_flag, short_amount
    );
endinterface

// File: rtl/change_dispenser.sv
// Change payout: greedy $5/$2/$1 ejection as timed solenoid pulses, with per-tube
// stock tracking and reporting of any amount that could not be paid back.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int COIN_CAP     = 15,
    parameter int INIT_COINS   = 10
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_5,
        COIN_2,
        COIN_1
    } coin_e;

    state_e           state_q;
    coin_e            coin_q;
    logic [7:0]       remaining_q;
    logic [3:0]       tube5_q;
    logic [3:0]       tube2_q;
    logic [3:0]       tube1_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eject5_q;
    logic             eject2_q;
    logic             eject1_q;
    logic             done_q;
    logic             short_flag_q;
    logic [7:0]       short_amount_q;

    coin_e pick_coin;

    // Largest coin that fits the remainder and is still in stock; empty tubes fall through.
    always_comb begin
        // NOTE: default first so every path assigns pick_coin and no latch is inferred.
        pick_coin = COIN_NONE;
        if (remaining_q >= 8'd5 && tube5_q != 4'd0) begin
            pick_coin = COIN_5;
        end else if (remaining_q >= 8'd2 && tube2_q != 4'd0) begin
            pick_coin = COIN_2;
        end else if (remaining_q >= 8'd1 && tube1_q != 4'd0) begin
            pick_coin = COIN_1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            coin_q         <= COIN_NONE;
            remaining_q    <= 8'd0;
            tube5_q        <= 4'(INIT_COINS);
            tube2_q        <= 4'(INIT_COINS);
            tube1_q        <= 4'(INIT_COINS);
            cnt_q          <= '0;
            eject5_q       <= 1'b0;
            eject2_q       <= 1'b0;
            eject1_q       <= 1'b0;
            done_q         <= 1'b0;
            short_flag_q   <= 1'b0;
            short_amount_q <= 8'd0;
        end else begin
            // NOTE: non-blocking throughout, so every term below reads pre-edge state.
            // Outputs are registered from the current state and so trail it by one cycle.
            eject5_q <= (state_q == S_PULSE) && (coin_q == COIN_5);
            eject2_q <= (state_q == S_PULSE) && (coin_q == COIN_2);
            eject1_q <= (state_q == S_PULSE) && (coin_q == COIN_1);
            done_q   <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                short_amount_q <= remaining_q;
                short_flag_q   <= (remaining_q != 8'd0);
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        remaining_q <= bus.req_amount;
                        state_q     <= S_SELECT;
                    end else if (bus.refill) begin
                        tube5_q <= 4'(COIN_CAP);
                        tube2_q <= 4'(COIN_CAP);
                        tube1_q <= 4'(COIN_CAP);
                    end
                end
                S_SELECT: begin
                    coin_q <= pick_coin;
                    cnt_q  <= '0;
                    case (pick_coin)
                        COIN_5: begin
                            tube5_q     <= tube5_q - 4'd1;
                            remaining_q <= remaining_q - 8'd5;
                            state_q     <= S_PULSE;
                        end
                        COIN_2: begin
                            tube2_q     <= tube2_q - 4'd1;
                            remaining_q <= remaining_q - 8'd2;
                            state_q     <= S_PULSE;
                        end
                        COIN_1: begin
                            tube1_q     <= tube1_q - 4'd1;
                            remaining_q <= remaining_q - 8'd1;
                            state_q     <= S_PULSE;
                        end
                        default: state_q <= S_DONE;
                    endcase
                end
                S_PULSE: begin
                    if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_SELECT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE) && rst;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.eject5       = eject5_q;
    assign bus.eject2       = eject2_q;
    assign bus.eject1       = eject1_q;
    assign bus.tube5        = tube5_q;
    assign bus.tube2        = tube2_q;
    assign bus.tube1        = tube1_q;
    assign bus.done         = done_q;
    assign bus.short_flag   = short_flag_q;
    assign bus.short_amount = short_amount_q;

    // Two solenoids firing together would jam the return chute.
    a_one_eject: assert property (@(posedge clk) disable iff (!rst)
        $onehot0({eject5_q, eject2_q, eject1_q}));
endmodule
